mem_stage_ctrl: RTL and testbench
=================================

MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 Parameter DATA_W, default 16: memory data and write-data width.
REQ-002 Parameter HI_W, default 16: width of the ALU upper field passed through unchanged.
REQ-003 Parameter ADDR_W, default 16: width of the address field, taken from the ALU low bits.
REQ-004 Parameter DEPTH, default 256: number of memory words; legal range 2..2^ADDR_W.
REQ-005 Parameter WAIT_CYCLES, default 0: extra wait states per memory access; legal range 0..15.
REQ-006 Port clk, input, 1: single clock; all state changes on the rising edge.
REQ-007 Port rst, input, 1: reset, asynchronous and active-low.
REQ-008 Port halt_sys, input, 1: global freeze.
REQ-009 Port in_valid, input, 1: a stage-three operation is presented.
REQ-010 Port in_ready, output, 1: the block can accept an operation this cycle.
REQ-011 Port s3_alu, input, HI_W+DATA_W: ALU result; the low ADDR_W bits form the word address.
REQ-012 Port s3_memc, input, 2: bit0 = memwr (store), bit1 = mem2r (load; result low field comes from memory).
REQ-013 Port s3_r1_data, input, DATA_W: store data.
REQ-014 Port out_valid, output, 1: one-cycle pulse marking s3_data as updated.
REQ-015 Port s3_data, output, HI_W+DATA_W: stage result.
REQ-016 Port addr_err, output, 1: one-cycle pulse, coincident with out_valid, when the address is out of range.

Function
REQ-017 Accept condition: in_valid && in_ready && !halt_sys; inputs are captured into internal registers on acceptance.
REQ-018 FSM states: IDLE and BUSY; in_ready = 1 only in IDLE and when halt_sys = 0.
REQ-019 No-op (s3_memc = 00), or any access with WAIT_CYCLES = 0:
- completes the cycle after acceptance;
- out_valid pulses then;
- FSM stays in IDLE.
REQ-020 Load or store with WAIT_CYCLES > 0:
- IDLE -> BUSY on acceptance; counter loads WAIT_CYCLES;
- counter decrements each unfrozen cycle;
- completion occurs the cycle after the counter reaches 0; BUSY -> IDLE then.
- Total latency from acceptance to out_valid is WAIT_CYCLES+1 cycles.
REQ-021 Store: memory[addr] <= captured s3_r1_data, written only at the completion edge.
REQ-022 Load: the low field of s3_data is memory[addr], read at the completion edge.
REQ-023 s3_data composition:
- upper HI_W bits = captured ALU upper bits;
- lower DATA_W bits = memory data when mem2r = 1, else captured ALU low bits.
REQ-024 s3_memc = 11 is executed as a store; s3_data low field = ALU low bits; no read occurs.
REQ-025 s3_data holds its value between completions; out_valid = 0 except on completion cycles.
REQ-026 Address >= DEPTH:
- store suppressed;
- load returns zero in the low field;
- addr_err pulses with out_valid;
- timing is unchanged.
REQ-027 Back-to-back operations: a new operation is accepted in the same cycle as a BUSY->IDLE completion is not possible (in_ready = 0 in BUSY); in IDLE with WAIT_CYCLES = 0, one operation per cycle is sustained.
REQ-028 halt_sys = 1:
- counter, FSM, s3_data and memory are frozen;
- no write occurs and no acceptance occurs;
- out_valid and addr_err are forced to 0;
- a completion that would fall in a halted cycle occurs on the first cycle after halt_sys deasserts.
REQ-029 Store-then-load to the same address: the load returns the newly stored value.

Reset
REQ-030 While rst = 0, asynchronously: FSM = IDLE, counter = 0, s3_data = 0, out_valid = 0, addr_err = 0, internal capture registers = 0.
REQ-031 Memory contents are unaffected by reset.
REQ-032 Reset during BUSY aborts the operation: no write, no out_valid.
REQ-033 in_ready = 1 on the first cycle after rst deasserts, provided halt_sys = 0.

Verification
REQ-034 Setup: DATA_W=16, HI_W=16, DEPTH=256, WAIT_CYCLES=2.
- Store s3_alu=0x0000_0010, s3_r1_data=0xBEEF, memc=01 -> out_valid 3 cycles after acceptance, in_ready=0 for 3 cycles.
- Then load at the same address, memc=10 -> s3_data=0x0000_BEEF.
REQ-035 No-op s3_alu=0x1234_5678, memc=00 -> s3_data=0x1234_5678 with out_valid one cycle after acceptance, FSM never leaves IDLE.
REQ-036 Load s3_alu=0xAAAA_0100 (addr 256 >= DEPTH) -> s3_data=0xAAAA_0000, addr_err=1 coincident with out_valid.
- Store to 0x0100 -> no memory change, addr_err=1.
REQ-037 Store 0x1111 to addr 0x20, halt_sys held for 4 cycles mid-BUSY -> no write during the halt, out_valid delayed by exactly 4 cycles, memory[0x20]=0x1111 afterward.
REQ-038 Store 0x2222 to addr 0x30 over prior 0x5555, rst pulled low in BUSY -> outputs zero immediately, load of addr 0x30 after reset returns 0x5555.
REQ-039 memc=11, s3_alu=0x0001_0040, r1=0x7777 -> memory[0x40]=0x7777, s3_data=0x0001_0040.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// rtl/mem_stage_ctrl.sv - stage-three memory access controller with wait states and halt
module mem_stage_ctrl #(
  parameter int DATA_W      = 16,
  parameter int HI_W        = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   halt_sys,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [HI_W+DATA_W-1:0] s3_alu,
  input  logic [1:0]             s3_memc,
  input  logic [DATA_W-1:0]      s3_r1_data,
  output logic                   out_valid,
  output logic [HI_W+DATA_W-1:0] s3_data,
  output logic                   addr_err
);

  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [3:0]      WAIT_L  = 4'(WAIT_CYCLES);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t            state;
  logic [3:0]        cnt;
  logic              pend;       // a captured operation is waiting to complete
  logic [HI_W-1:0]   cap_hi;
  logic [DATA_W-1:0] cap_lo;
  logic [DATA_W-1:0] cap_wdata;
  logic              cap_wr;
  logic              cap_rd;
  logic              ov_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [0:DEPTH-1];

  logic              accept;
  logic              complete;
  logic              in_range;
  logic              is_load;
  logic              do_write;
  logic [ADDR_W-1:0] addr;
  logic [IDX_W-1:0]  idx;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] lo_result;

  assign in_ready  = (state == IDLE) && !halt_sys;
  assign accept    = in_valid && in_ready;
  assign addr      = cap_lo[ADDR_W-1:0];
  assign idx       = addr[IDX_W-1:0];
  assign in_range  = ({1'b0, addr} < DEPTH_L);
  // memc = 11 behaves as a plain store, so a load needs the write bit clear
  assign is_load   = cap_rd && !cap_wr;
  assign complete  = !halt_sys &&
                     (((state == IDLE) && pend) || ((state == BUSY) && (cnt == 4'd0)));
  assign do_write  = complete && cap_wr && in_range;
  assign rd_data   = (is_load && in_range) ? mem[idx] : '0;
  assign lo_result = is_load ? rd_data : cap_lo;

  // A pulse raised just before a halt is held back and shown once the halt lifts
  assign out_valid = ov_q && !halt_sys;
  assign addr_err  = err_q && !halt_sys;

  // Memory array: written only on the completion edge of an in-range store, never reset
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[idx] <= cap_wdata;
    end
  end

  // Control FSM: capture on acceptance, count wait states, register the stage result
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      pend      <= 1'b0;
      cap_hi    <= '0;
      cap_lo    <= '0;
      cap_wdata <= '0;
      cap_wr    <= 1'b0;
      cap_rd    <= 1'b0;
      ov_q      <= 1'b0;
      err_q     <= 1'b0;
      s3_data   <= '0;
    end else begin
      if (complete) begin
        ov_q    <= 1'b1;
        err_q   <= (cap_wr || cap_rd) && !in_range;
        s3_data <= {cap_hi, lo_result};
        pend    <= 1'b0;
      end else if (!halt_sys) begin
        ov_q  <= 1'b0;
        err_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          // A pending no-op may complete on this same edge; the new capture overrides pend
          if (accept) begin
            cap_hi    <= s3_alu[HI_W+DATA_W-1:DATA_W];
            cap_lo    <= s3_alu[DATA_W-1:0];
            cap_wdata <= s3_r1_data;
            cap_wr    <= s3_memc[0];
            cap_rd    <= s3_memc[1];
            pend      <= 1'b1;
            if ((WAIT_L != 4'd0) && (s3_memc != 2'b00)) begin
              state <= BUSY;
              cnt   <= WAIT_L;
            end
          end
        end
        BUSY: begin
          if (!halt_sys) begin
            if (cnt == 4'd0) begin
              state <= IDLE;
            end else begin
              cnt <= cnt - 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb/tb_mem_stage_ctrl.sv - self-checking bench for mem_stage_ctrl
module tb_mem_stage_ctrl;

  localparam int WAITC = 2;

  logic        clk        = 1'b0;
  logic        rst        = 1'b1;
  logic        halt_sys   = 1'b0;
  logic        in_valid   = 1'b0;
  logic        in_valid0  = 1'b0;
  logic [31:0] s3_alu     = '0;
  logic [1:0]  s3_memc    = '0;
  logic [15:0] s3_r1_data = '0;
  logic        in_ready, out_valid, addr_err;
  logic [31:0] s3_data;
  logic        rdy0, ov0, err0;
  logic [31:0] data0;

  int   checks = 0;
  int   passes = 0;
  logic chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_stage_ctrl #(.DATA_W(16), .HI_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(WAITC)) u_dut (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid), .in_ready(in_ready),
    .s3_alu(s3_alu), .s3_memc(s3_memc), .s3_r1_data(s3_r1_data),
    .out_valid(out_valid), .s3_data(s3_data), .addr_err(addr_err)
  );

  mem_stage_ctrl #(.DATA_W(16), .HI_W(16), .ADDR_W(16), .DEPTH(256), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst), .halt_sys(halt_sys), .in_valid(in_valid0), .in_ready(rdy0),
    .s3_alu(s3_alu), .s3_memc(s3_memc), .s3_r1_data(s3_r1_data),
    .out_valid(ov0), .s3_data(data0), .addr_err(err0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: each accepted op finishes after a fixed number of unhalted edges
  logic [15:0] m_mem [0:255];
  logic        m_pend   = 1'b0;
  logic        m_busy   = 1'b0;
  int          m_rem    = 0;
  logic [31:0] m_alu    = '0;
  logic [1:0]  m_memc   = '0;
  logic [15:0] m_wd     = '0;
  logic        exp_out  = 1'b0;
  logic        exp_err  = 1'b0;
  logic [31:0] exp_data = '0;

  always @(posedge clk or negedge rst) begin : model
    logic        take;
    logic        inr;
    logic [15:0] a;
    logic [15:0] lo;
    if (!rst) begin
      m_pend   = 1'b0;
      m_busy   = 1'b0;
      exp_out  = 1'b0;
      exp_err  = 1'b0;
      exp_data = '0;
    end else begin
      take = in_valid && !halt_sys && !(m_pend && m_busy);
      if (!halt_sys) begin
        exp_out = 1'b0;
        exp_err = 1'b0;
      end
      if (m_pend && !halt_sys) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) begin
          a   = m_alu[15:0];
          inr = (a < 16'd256);
          lo  = a;
          if (m_memc[0]) begin
            if (inr) m_mem[a[7:0]] = m_wd;
          end else if (m_memc[1]) begin
            lo = inr ? m_mem[a[7:0]] : 16'h0000;
          end
          exp_data = {m_alu[31:16], lo};
          exp_out  = 1'b1;
          exp_err  = (m_memc != 2'b00) && !inr;
          m_pend   = 1'b0;
        end
      end
      if (take) begin
        m_alu  = s3_alu;
        m_memc = s3_memc;
        m_wd   = s3_r1_data;
        m_pend = 1'b1;
        m_busy = (s3_memc != 2'b00);
        m_rem  = m_busy ? WAITC + 1 : 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("out_valid", {31'b0, out_valid}, {31'b0, exp_out && !halt_sys});
      chk("addr_err", {31'b0, addr_err}, {31'b0, exp_err && !halt_sys});
      chk("s3_data", s3_data, exp_data);
      chk("in_ready", {31'b0, in_ready}, {31'b0, !halt_sys && !(m_pend && m_busy)});
    end
  end

  // Called at #1 after an edge; the op is accepted on the following edge
  task automatic issue(input logic [31:0] alu, input logic [1:0] mc, input logic [15:0] wd);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) chk("issue_timeout", 32'd0, 32'd1);
    s3_alu     = alu;
    s3_memc    = mc;
    s3_r1_data = wd;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
  endtask

  task automatic wait_done(output int lat, output int nlow);
    lat  = 0;
    nlow = 0;
    while (lat < 40) begin
      if (!in_ready) nlow++;
      @(posedge clk); #1;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) chk("done_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] t_alu [0:4] = '{32'h00C0_0001, 32'h00C0_0002, 32'h00D0_0001, 32'h00C0_0003, 32'h00D0_0003};
  logic [1:0]  t_mc  [0:4] = '{2'b01, 2'b01, 2'b10, 2'b01, 2'b10};
  logic [15:0] t_wd  [0:4] = '{16'h1001, 16'h2002, 16'h0000, 16'h3003, 16'h0000};
  logic [31:0] t_exp [0:4] = '{32'h00C0_0001, 32'h00C0_0002, 32'h00D0_1001, 32'h00C0_0003, 32'h00D0_3003};

  initial begin
    int lat;
    int nlow;
    #2;
    rst    = 1'b0;
    chk_on = 1'b1;
    #1;
    chk("rst_s3_data", s3_data, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_addr_err", {31'b0, addr_err}, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    chk("ready_after_rst", {31'b0, in_ready}, 32'd1);

    issue(32'h1234_5678, 2'b00, 16'h0000);
    chk("noop_stays_idle", {31'b0, in_ready}, 32'd1);
    wait_done(lat, nlow);
    chk("noop_lat", lat, 32'd1);
    chk("noop_data", s3_data, 32'h1234_5678);

    issue(32'h0000_0010, 2'b01, 16'hBEEF);
    wait_done(lat, nlow);
    chk("store_lat", lat, 32'd3);
    chk("store_busy_cycles", nlow, 32'd3);
    chk("store_data", s3_data, 32'h0000_0010);
    issue(32'h0000_0010, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("load_data", s3_data, 32'h0000_BEEF);

    issue(32'hA1A1_0001, 2'b00, 16'h0000);
    issue(32'hB2B2_0002, 2'b00, 16'h0000);
    issue(32'hC3C3_0003, 2'b00, 16'h0000);
    issue(32'h5A5A_0010, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("b2b_load_lat", lat, 32'd3);
    chk("b2b_load_data", s3_data, 32'h5A5A_BEEF);

    issue(32'h0000_0000, 2'b01, 16'h0ABC);
    wait_done(lat, nlow);
    issue(32'hAAAA_0100, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("oob_load_lat", lat, 32'd3);
    chk("oob_load_data", s3_data, 32'hAAAA_0000);
    chk("oob_load_err", {31'b0, addr_err}, 32'd1);
    issue(32'h0000_0100, 2'b01, 16'h9999);
    wait_done(lat, nlow);
    chk("oob_store_err", {31'b0, addr_err}, 32'd1);
    issue(32'h0000_0000, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("no_alias_data", s3_data, 32'h0000_0ABC);
    chk("no_alias_err", {31'b0, addr_err}, 32'd0);

    issue(32'h0000_0020, 2'b01, 16'h1111);
    @(posedge clk); #1;
    halt_sys = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    halt_sys = 1'b0;
    wait_done(lat, nlow);
    chk("halt_total_lat", lat + 5, 32'd7);
    issue(32'h0000_0020, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("halt_store_data", s3_data, 32'h0000_1111);

    issue(32'h0001_0040, 2'b11, 16'h7777);
    wait_done(lat, nlow);
    chk("memc11_lat", lat, 32'd3);
    chk("memc11_data", s3_data, 32'h0001_0040);
    issue(32'h0000_0040, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("memc11_mem", s3_data, 32'h0000_7777);

    issue(32'h0000_0030, 2'b01, 16'h5555);
    wait_done(lat, nlow);
    issue(32'h0000_0030, 2'b01, 16'h2222);
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
    chk("abort_s3_data", s3_data, 32'h0);
    chk("abort_addr_err", {31'b0, addr_err}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    chk("ready_after_abort", {31'b0, in_ready}, 32'd1);
    repeat (4) @(posedge clk);
    #1;
    issue(32'h0000_0030, 2'b10, 16'h0000);
    wait_done(lat, nlow);
    chk("abort_kept_mem", s3_data, 32'h0000_5555);

    for (int i = 0; i <= 5; i++) begin
      if (i < 5) begin
        s3_alu     = t_alu[i];
        s3_memc    = t_mc[i];
        s3_r1_data = t_wd[i];
        in_valid0  = 1'b1;
        chk("w0_ready", {31'b0, rdy0}, 32'd1);
      end else begin
        in_valid0 = 1'b0;
      end
      @(posedge clk); #1;
      if (i > 0) begin
        chk("w0_valid", {31'b0, ov0}, 32'd1);
        chk("w0_data", data0, t_exp[i-1]);
      end
    end
    @(posedge clk); #1;
    chk("w0_idle_valid", {31'b0, ov0}, 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
